// File: rtl/fp32_mul_pipe.sv
// IEEE-754 single-precision multiplier: operand register plus 3 compute stages, FTZ/DAZ.
// Optional sticky overflow/underflow flags when FPMUL_STICKY_FLAGS_EN is defined.
module fp32_mul_pipe #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  r_mode,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  output logic        out_valid,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
`ifdef FPMUL_STICKY_FLAGS_EN
  ,
  input  logic        flag_clr,
  output logic        ovrf_sticky,
  output logic        udrf_sticky
`endif
);
  localparam int STAGES = 3;
  localparam logic [2:0] RM_RTZ = 3'b001, RM_RDN = 3'b010, RM_RUP = 3'b011, RM_RMM = 3'b100;
  localparam logic [30:0] INF_MAG = {8'hFF, 23'h0};
  localparam logic [30:0] MAX_MAG = {8'hFE, {23{1'b1}}};

  typedef struct packed {
    logic [2:0]  rm;
    logic [31:0] x;
    logic [31:0] y;
  } in_t;

  typedef struct packed {
    logic        sign, nan, inf, zero;
    logic [2:0]  rm;
    logic [9:0]  exp;
    logic [47:0] prod;
  } s1_t;

  typedef struct packed {
    logic        sign, nan, inf, zero;
    logic [2:0]  rm;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        g, r, st;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  in_t in_q;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end

  always_ff @(posedge clk) begin
    in_q <= '{rm: r_mode, x: fp_X, y: fp_Y};
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign out_valid = vld_pipe[STAGES];

  // Stage 1: classify and multiply. Exponent field 0 is zero (denormals flushed).
  logic [7:0]  ex, ey;
  logic [22:0] fx, fy;
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

  assign ex = in_q.x[30:23];
  assign ey = in_q.y[30:23];
  assign fx = in_q.x[22:0];
  assign fy = in_q.y[22:0];
  assign x_zero = (ex == 8'h00);
  assign y_zero = (ey == 8'h00);
  assign x_inf  = (ex == 8'hFF) && (fx == '0);
  assign y_inf  = (ey == 8'hFF) && (fy == '0);
  assign x_nan  = (ex == 8'hFF) && (fx != '0);
  assign y_nan  = (ey == 8'hFF) && (fy != '0);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_q.x[31] ^ in_q.y[31];
    s1_d.nan  = x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero);
    s1_d.inf  = x_inf | y_inf;
    s1_d.zero = x_zero | y_zero;
    s1_d.rm   = in_q.rm;
    // Two's complement in 10 bits; negative values mean certain underflow.
    s1_d.exp  = {2'b00, ex} + {2'b00, ey} - 10'd127;
    s1_d.prod = {1'b1, fx} * {1'b1, fy};
  end

  // Stage 2: normalize to 24 bits plus guard/round/sticky.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.nan  = s1_q.nan;
    s2_d.inf  = s1_q.inf;
    s2_d.zero = s1_q.zero;
    s2_d.rm   = s1_q.rm;
    if (s1_q.prod[47]) begin
      s2_d.mant = s1_q.prod[47:24];
      s2_d.g    = s1_q.prod[23];
      s2_d.r    = s1_q.prod[22];
      s2_d.st   = |s1_q.prod[21:0];
      s2_d.exp  = s1_q.exp + 10'd1;
    end else begin
      s2_d.mant = s1_q.prod[46:23];
      s2_d.g    = s1_q.prod[22];
      s2_d.r    = s1_q.prod[21];
      s2_d.st   = |s1_q.prod[20:0];
      s2_d.exp  = s1_q.exp;
    end
  end

  // Stage 3: round, detect over/underflow, pack.
  logic        inc;
  logic [24:0] mant_r;
  logic [9:0]  exp_r;
  logic [22:0] frac_r;
  logic [30:0] ovf_mag;
  logic [31:0] z_d;
  logic        ov_d, un_d;

  always_comb begin
    case (s2_q.rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_q.sign & (s2_q.g | s2_q.r | s2_q.st);
      RM_RUP:  inc = ~s2_q.sign & (s2_q.g | s2_q.r | s2_q.st);
      RM_RMM:  inc = s2_q.g;
      default: inc = s2_q.g & (s2_q.r | s2_q.st | s2_q.mant[0]);
    endcase
    mant_r = {1'b0, s2_q.mant} + {24'd0, inc};
    exp_r  = s2_q.exp + {9'd0, mant_r[24]};
    frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    case (s2_q.rm)
      RM_RTZ:  ovf_mag = MAX_MAG;
      RM_RDN:  ovf_mag = s2_q.sign ? INF_MAG : MAX_MAG;
      RM_RUP:  ovf_mag = s2_q.sign ? MAX_MAG : INF_MAG;
      default: ovf_mag = INF_MAG;
    endcase

    z_d  = {s2_q.sign, 31'd0};
    ov_d = 1'b0;
    un_d = 1'b0;
    if (s2_q.nan)                               z_d = CANON_NAN;
    else if (s2_q.inf)                          z_d = {s2_q.sign, INF_MAG};
    else if (s2_q.zero)                         z_d = {s2_q.sign, 31'd0};
    else if (s2_q.exp[9] || s2_q.exp == 10'd0)  un_d = 1'b1;
    else if (exp_r >= 10'd255) begin
      ov_d = 1'b1;
      z_d  = {s2_q.sign, ovf_mag};
    end else                                    z_d = {s2_q.sign, exp_r[7:0], frac_r};
  end

  // Result registers hold their value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fp_Z <= '0;
      ovrf <= 1'b0;
      udrf <= 1'b0;
    end else if (vld_pipe[STAGES-1]) begin
      fp_Z <= z_d;
      ovrf <= ov_d;
      udrf <= un_d;
    end
  end

`ifdef FPMUL_STICKY_FLAGS_EN
  // A flag seen in the same cycle as flag_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovrf_sticky <= 1'b0;
      udrf_sticky <= 1'b0;
    end else begin
      if (out_valid && ovrf) ovrf_sticky <= 1'b1;
      else if (flag_clr)     ovrf_sticky <= 1'b0;
      if (out_valid && udrf) udrf_sticky <= 1'b1;
      else if (flag_clr)     udrf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/fp32_mul_pipe.md
Name: fp32_mul_pipe

Overview:
- IEEE-754 single-precision multiplier: the DUT that is driven through the team's FP-multiplier interface.
- Consumes r_mode/fp_X/fp_Y; produces fp_Z/ovrf/udrf.
- 3-stage pipeline with a valid tag, one result per cycle, fixed latency.
- Denormal inputs and outputs are flushed to zero.

Parameters:
- CANON_NAN, 32'h7FC00000, bit pattern returned for every NaN result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands and r_mode valid this cycle
- r_mode  input  3  rounding mode
- fp_X  input  32  operand A
- fp_Y  input  32  operand B
- out_valid  output  1  fp_Z/ovrf/udrf valid this cycle
- fp_Z  output  32  product
- ovrf  output  1  overflow flag for this result
- udrf  output  1  underflow flag for this result

Behaviour:
- Reset values: out_valid=0, fp_Z=0, ovrf=0, udrf=0, all stage valid bits 0.
- rst is sampled on clk; it kills all in-flight operations, with no partial outputs.
- Latency: an operation sampled with in_valid=1 at edge N appears with out_valid=1 after edge N+3.
- Throughput is 1 per cycle. There is no backpressure.
- Bubbles propagate as out_valid=0. While out_valid=0, fp_Z and the flags hold their last values.
- r_mode is registered with its operands and travels with them.
- r_mode encoding:
  - 000 RNE (nearest, ties to even)
  - 001 RTZ
  - 010 RDN (toward -inf)
  - 011 RUP (toward +inf)
  - 100 RMM (nearest, ties away)
  - 101-111 treated as RNE
- Stage 1 (unpack/multiply):
  - Sign = sX xor sY.
  - Exponent field 0 means zero (denormals are flushed).
  - Classify each operand as zero, inf, NaN or normal.
  - 24x24 mantissa product gives 48 bits.
  - Unbiased sum eS = eX + eY - 127, held in 10-bit signed arithmetic.
- Stage 2 (normalize):
  - If product bit47 = 1: shift right 1, eS += 1.
  - Keep 24 mantissa bits plus guard bit, round bit and sticky (OR of the remaining bits).
- Stage 3 (round/pack):
  - Apply the rounding increment per mode. A mantissa carry-out renormalizes and increments the exponent.
  - Overflow: post-round biased exponent >= 255 gives ovrf=1.
    - RNE/RMM: fp_Z = ±inf.
    - RTZ: fp_Z = ±0x7F7FFFFF.
    - RDN: +max finite or -inf.
    - RUP: +inf or -max finite.
  - Underflow: pre-round biased exponent <= 0 gives fp_Z = signed zero and udrf=1, in every rounding mode.
- Special operands:
  - NaN*any or inf*0 → fp_Z = CANON_NAN, ovrf=0, udrf=0.
  - inf*nonzero → signed inf, flags 0.
  - zero*finite → signed zero, flags 0.
- ovrf and udrf are never both 1.

Optional Feature:
- Macro: FPMUL_STICKY_FLAGS_EN.
- When defined:
  - Adds input flag_clr (1 bit) and outputs ovrf_sticky and udrf_sticky (1 bit each).
  - Each sticky bit sets on any out_valid cycle whose corresponding flag is 1, and holds until flag_clr=1 or rst.
  - If flag_clr and a new flag occur in the same cycle, set wins.
  - Reset value is 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Basic product: 0x3FC00000 * 0x40000000, r_mode=000, single in_valid pulse → exactly 3 cycles later out_valid=1 for one cycle, fp_Z=0x40400000, ovrf=0, udrf=0.
- Rounding modes: 0x3F800001 * 0x3F800001 → RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003, RDN 0x3F800002. The negated-X variant under RDN → 0xBF800003.
- Overflow: 0x7F7FFFFF * 0x40000000 → r_mode=000 gives 0x7F800000 with ovrf=1; r_mode=001 gives 0x7F7FFFFF with ovrf=1.
- Underflow/flush: 0x00800000 * 0x3F000000 → fp_Z=0x00000000, udrf=1. A denormal input 0x00000001 * 0x3F800000 → fp_Z=0x00000000, udrf=0.
- Specials: 0x7F800000 * 0x00000000 → 0x7FC00000; 0xFF800000 * 0x40000000 → 0xFF800000; 0x7FC12345 * 0x3F800000 → 0x7FC00000; all flags 0.
- Streaming and reset: 5 back-to-back valid operands give 5 consecutive correct results in order. Asserting rst for 1 cycle with 3 operations in flight → out_valid=0 from the next cycle, and none of the 3 results ever emerge.
- Build-option check: with FPMUL_STICKY_FLAGS_EN defined, sticky bits set after the overflow case and clear on flag_clr.
